pipe_trace_buffer: RTL and testbench
====================================

Name: pipe_trace_buffer

Overview:
- Synthesizable, parametrised trace capture block for the rv32i pipeline; replaces per-stage $fdisplay logging with on-chip event buffering.
- NUM_CH pipeline probe points (e.g. IF/ID/EX/MEM/WB) raise single-cycle event pulses with a payload.
- Events are timestamped, arbitrated round-robin into a shared FIFO and drained over a valid/ready stream toward a debug port or UVM monitor.
- Lost events are counted and flagged, never silently merged.

Parameters:
- NUM_CH, 4, number of event channels (1..8)
- DATA_W, 64, payload width per event
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp counter width
- CH_W derived: $clog2(NUM_CH), minimum 1; CNT_W derived: $clog2(DEPTH+1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- en_i  in  1  capture enable
- clear_i  in  1  synchronous flush of all state
- ev_valid_i  in  NUM_CH  per-channel event pulse; no backpressure
- ev_data_i  in  NUM_CH*DATA_W  payloads; channel k at [k*DATA_W +: DATA_W]
- tr_valid_o  out  1  head entry valid
- tr_ready_i  in  1  consumer accepts head
- tr_data_o  out  DATA_W  head payload
- tr_ch_o  out  CH_W  head channel index
- tr_ts_o  out  TS_W  head capture timestamp
- count_o  out  CNT_W  FIFO occupancy
- drop_cnt_o  out  16  dropped-event counter, saturating
- overflow_o  out  1  sticky: at least one event dropped

Behaviour:
- Reset (rst_i=0, async): every output is 0. Holding registers are empty, FIFO pointers are 0, ts=0, rr_ptr=0.
- Timestamp: ts increments by 1 each cycle while en_i=1 and wraps from 2^TS_W-1 to 0. It is frozen while en_i=0.
- Capture stage: one holding register per channel, storing {data, ts}.
  - On ev_valid_i[k]=1 with en_i=1, channel k's register loads when it is empty, or when it is being granted in the same cycle (free-and-refill).
  - Otherwise the event is dropped: drop_cnt_o increments (saturates at 16'hFFFF) and overflow_o sets.
  - Simultaneous drops on several channels in one cycle each count: the increment equals the number of dropped events, and the sum saturates.
  - With en_i=0, events are ignored and not counted.
- Arbiter: round-robin over occupied holding registers.
  - Grant goes to the first occupied channel at index >= rr_ptr, searching cyclically.
  - After a grant, rr_ptr = granted+1 mod NUM_CH. rr_ptr is unchanged when there is no grant.
  - At most one grant per cycle.
  - A grant is allowed only when count_o < DEPTH, or when count_o == DEPTH and a pop occurs in the same cycle.
- FIFO: first-word-fall-through.
  - tr_valid_o = (count_o != 0). Head fields are driven directly from storage.
  - Pop occurs when tr_valid_o & tr_ready_i.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Head fields are stable while tr_valid_o=1 and tr_ready_i=0.
  - Head fields are don't-care when tr_valid_o=0 (held at last value).
- Latency: an event pulse in cycle N is held at edge N+1, granted in cycle N+1 if uncontended, and has tr_valid_o=1 in cycle N+2. tr_ts_o carries ts as sampled in cycle N.
- Drain continues while en_i=0.
- clear_i=1 (synchronous, highest priority):
  - Empties the holding registers and FIFO; zeroes ts, drop_cnt_o, overflow_o and rr_ptr.
  - Events in that cycle are discarded and not counted.
  - A pop in that cycle is discarded.
- Async reset mid-transfer abandons all entries with no completion.

Optional Feature:
- Macro: TRACE_TS_EN.
- Defined: the timestamp counter and per-entry TS_W storage exist, and tr_ts_o is driven as specified above.
- Undefined: the counter and storage are removed and tr_ts_o is tied to 0. All other behaviour and latency are identical.

Test Plan:
- Single event: ev_valid_i=4'b0001, data=64'hDEAD_BEEF_0000_0001 at ts=5, tr_ready_i=1 -> tr_valid_o high exactly 2 cycles later, tr_ch_o=0, tr_ts_o=5 (TRACE_TS_EN); count_o returns to 0.
- Round-robin: all 4 channels pulse in the same cycle with tr_ready_i=1 -> output order ch0,ch1,ch2,ch3 in consecutive cycles. Next all-channel burst with rr_ptr=0 starts at ch0 again; with rr_ptr=2, the order is 2,3,0,1.
- Full/backpressure: tr_ready_i=0, 20 single-channel events on ch1 spaced 2 cycles apart -> count_o stops at 16, one event occupies the holding register, subsequent 3 drop. Result: drop_cnt_o=3, overflow_o=1. Raising tr_ready_i drains 17 entries in FIFO order.
- Push/pop at full: count_o=16, tr_ready_i=1, new event on ch2 -> count_o stays 16 and the new entry lands at the tail.
- Saturation and clear: force 70000 drops -> drop_cnt_o=16'hFFFF. Then clear_i for 1 cycle -> count_o=0, tr_valid_o=0, drop_cnt_o=0, overflow_o=0, ts restarts at 0.
- Async reset mid-drain: rst_i low with count_o=7 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first event exits on ch0's slot with tr_ts_o matching its capture cycle.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
// ---------------------------------------------------------------------------
// pipe_trace_buffer
//
// On-chip trace capture for the rv32i pipeline. NUM_CH probe points raise
// single-cycle event pulses with a payload. Each event is captured into a
// per-channel holding register together with a timestamp. A round-robin
// arbiter moves held events into a shared first-word-fall-through FIFO,
// which drains over a valid/ready stream. Events that find their holding
// register busy are dropped, counted (saturating) and flagged (sticky).
//
// Optional feature macro: TRACE_TS_EN
//   defined   : timestamp counter and per-entry timestamp storage exist,
//               tr_ts_o carries the capture timestamp of the head entry.
//   undefined : counter and storage are removed, tr_ts_o is tied to 0.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous reset, active-low
//   en_i        capture enable (timestamp runs, events accepted)
//   clear_i     synchronous flush of all state, highest priority
//   ev_valid_i  per-channel event pulse (no backpressure)
//   ev_data_i   payloads, channel k at [k*DATA_W +: DATA_W]
//   tr_valid_o  head entry valid
//   tr_ready_i  consumer accepts head
//   tr_data_o   head payload
//   tr_ch_o     head channel index
//   tr_ts_o     head capture timestamp
//   count_o     FIFO occupancy
//   drop_cnt_o  dropped-event counter, saturating at 16'hFFFF
//   overflow_o  sticky: at least one event dropped
// ---------------------------------------------------------------------------
module pipe_trace_buffer #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 16,
    parameter  int TS_W   = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [NUM_CH-1:0]        ev_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] ev_data_i,
    output logic                     tr_valid_o,
    input  logic                     tr_ready_i,
    output logic [DATA_W-1:0]        tr_data_o,
    output logic [CH_W-1:0]          tr_ch_o,
    output logic [TS_W-1:0]          tr_ts_o,
    output logic [CNT_W-1:0]         count_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     overflow_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DROP_W = $clog2(NUM_CH + 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_data_q [NUM_CH];

    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [CH_W-1:0]   mem_ch_q   [DEPTH];

`ifdef TRACE_TS_EN
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [TS_W-1:0]   hold_ts_q  [NUM_CH];
    logic [TS_W-1:0]   mem_ts_q   [DEPTH];
`endif

    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic              pop;
    logic              can_push;
    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] gnt_oh;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drop;
    logic [DROP_W-1:0] n_drop;
    logic [16:0]       drop_sum;
    int unsigned       idx;

    // Round-robin arbiter: first occupied channel at or after rr_q, cyclic.
    // A slot frees up at full occupancy only if the head leaves this cycle.
    always_comb begin
        pop      = (count_q != '0) && tr_ready_i;
        can_push = (count_q != CNT_W'(DEPTH)) || pop;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_oh   = '0;
        idx      = 0;
        if (can_push) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                idx = (32'(rr_q) + i) % NUM_CH;
                if (!gnt_vld && hold_v_q[idx]) begin
                    gnt_vld     = 1'b1;
                    gnt_idx     = CH_W'(idx);
                    gnt_oh[idx] = 1'b1;
                end
            end
        end
    end

    // Capture decision: a busy holding register still accepts an event if it
    // is being granted this cycle (free-and-refill); otherwise it drops.
    always_comb begin
        load   = '0;
        drop   = '0;
        n_drop = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (en_i && ev_valid_i[k]) begin
                if (!hold_v_q[k] || gnt_oh[k]) begin
                    load[k] = 1'b1;
                end else begin
                    drop[k] = 1'b1;
                end
            end
            n_drop = n_drop + DROP_W'(drop[k]);
        end
    end

    // Next-state for all scalar registers; clear_i overrides everything.
    always_comb begin
        hold_v_d   = (hold_v_q & ~gnt_oh) | load;
        wr_d       = wr_q + PTR_W'(gnt_vld);
        rd_d       = rd_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(gnt_vld) - CNT_W'(pop);
        rr_d       = rr_q;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q | (|drop);
`ifdef TRACE_TS_EN
        ts_d       = en_i ? ts_q + 1'b1 : ts_q;
`endif
        if (gnt_vld) begin
            rr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (clear_i) begin
            hold_v_d   = '0;
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
            rr_d       = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
`ifdef TRACE_TS_EN
            ts_d       = '0;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_v_q   <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            rr_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
`ifdef TRACE_TS_EN
            ts_q       <= '0;
`endif
        end else begin
            hold_v_q   <= hold_v_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
`ifdef TRACE_TS_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // Holding registers: payload and capture timestamp.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                hold_data_q[k] <= '0;
`ifdef TRACE_TS_EN
                hold_ts_q[k]   <= '0;
`endif
            end
        end else if (!clear_i) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (load[k]) begin
                    hold_data_q[k] <= ev_data_i[k*DATA_W +: DATA_W];
`ifdef TRACE_TS_EN
                    hold_ts_q[k]   <= ts_q;
`endif
                end
            end
        end
    end

    // FIFO storage. Reset clears it so the head fields read 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_ch_q[i]   <= '0;
`ifdef TRACE_TS_EN
                mem_ts_q[i]   <= '0;
`endif
            end
        end else if (!clear_i && gnt_vld) begin
            mem_data_q[wr_q] <= hold_data_q[gnt_idx];
            mem_ch_q[wr_q]   <= gnt_idx;
`ifdef TRACE_TS_EN
            mem_ts_q[wr_q]   <= hold_ts_q[gnt_idx];
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign tr_valid_o = (count_q != '0);
    assign tr_data_o  = mem_data_q[rd_q];
    assign tr_ch_o    = mem_ch_q[rd_q];
`ifdef TRACE_TS_EN
    assign tr_ts_o    = mem_ts_q[rd_q];
`else
    assign tr_ts_o    = '0;
`endif
    assign count_o    = count_q;
    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_trace_buffer
//
// Directed scenarios plus randomized traffic for pipe_trace_buffer, compared
// every cycle against a queue-based reference model of the trace buffer.
// ---------------------------------------------------------------------------
module tb_pipe_trace_buffer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 5;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     en_i;
    logic                     clear_i;
    logic [NUM_CH-1:0]        ev_valid_i;
    logic [NUM_CH*DATA_W-1:0] ev_data_i;
    logic                     tr_valid_o;
    logic                     tr_ready_i;
    logic [DATA_W-1:0]        tr_data_o;
    logic [CH_W-1:0]          tr_ch_o;
    logic [TS_W-1:0]          tr_ts_o;
    logic [CNT_W-1:0]         count_o;
    logic [15:0]              drop_cnt_o;
    logic                     overflow_o;

    pipe_trace_buffer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .clear_i    (clear_i),
        .ev_valid_i (ev_valid_i),
        .ev_data_i  (ev_data_i),
        .tr_valid_o (tr_valid_o),
        .tr_ready_i (tr_ready_i),
        .tr_data_o  (tr_data_o),
        .tr_ch_o    (tr_ch_o),
        .tr_ts_o    (tr_ts_o),
        .count_o    (count_o),
        .drop_cnt_o (drop_cnt_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: holding slots, a queue for the FIFO, plain counters.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [DATA_W-1:0] data;
        int unsigned       ch;
        int unsigned       ts;
    } ent_t;

    ent_t              m_q[$];
    bit                m_hv  [NUM_CH];
    logic [DATA_W-1:0] m_hd  [NUM_CH];
    int unsigned       m_hts [NUM_CH];
    int unsigned       m_ts;
    int                m_rr;
    int unsigned       m_drop;
    bit                m_ovf;

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < NUM_CH; k++) m_hv[k] = 1'b0;
        m_ts   = 0;
        m_rr   = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update();
        bit          pop;
        bit          can_push;
        int          g;
        int unsigned drops;
        ent_t        e;
        if (clear_i) begin
            model_reset();
            return;
        end
        pop      = (m_q.size() != 0) && tr_ready_i;
        can_push = (m_q.size() < DEPTH) || pop;
        g        = -1;
        if (can_push) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (g < 0 && m_hv[(m_rr + i) % NUM_CH]) g = (m_rr + i) % NUM_CH;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            e.data = m_hd[g];
            e.ch   = g;
            e.ts   = m_hts[g];
            m_q.push_back(e);
            m_hv[g] = 1'b0;
            m_rr    = (g + 1) % NUM_CH;
        end
        drops = 0;
        if (en_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ev_valid_i[k]) begin
                    if (!m_hv[k]) begin
                        m_hv[k]  = 1'b1;
                        m_hd[k]  = ev_data_i[k*DATA_W +: DATA_W];
                        m_hts[k] = m_ts;
                    end else begin
                        drops++;
                    end
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
        m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        if (drops != 0) m_ovf = 1'b1;
    endtask

    task automatic compare_all();
        logic [63:0] exp_ts;
        check("valid", 64'(tr_valid_o), 64'(m_q.size() != 0));
        check("count", 64'(count_o), 64'(m_q.size()));
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        if (m_q.size() != 0) begin
`ifdef TRACE_TS_EN
            exp_ts = 64'(m_q[0].ts);
`else
            exp_ts = 64'd0;
`endif
            check("head_data", 64'(tr_data_o), 64'(m_q[0].data));
            check("head_ch", 64'(tr_ch_o), 64'(m_q[0].ch));
            check("head_ts", 64'(tr_ts_o), exp_ts);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(tr_valid_o), 64'd0);
        check({tag, "_count"}, 64'(count_o), 64'd0);
        check({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
        check({tag, "_data"}, 64'(tr_data_o), 64'd0);
        check({tag, "_ch"}, 64'(tr_ch_o), 64'd0);
        check({tag, "_ts"}, 64'(tr_ts_o), 64'd0);
    endtask

    // One clock: inputs are already driven; update the model at the edge and
    // compare at the following falling edge.
    task automatic step();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic do_clear();
        ev_valid_i = '0;
        clear_i    = 1'b1;
        step();
        clear_i    = 1'b0;
    endtask

    task automatic burst_order(input int first);
        ev_valid_i = '1;
        for (int k = 0; k < NUM_CH; k++) ev_data_i[k*DATA_W +: DATA_W] = {$urandom, $urandom};
        step();
        ev_valid_i = '0;
        step();
        for (int i = 0; i < NUM_CH; i++) begin
            check("rr_order", 64'(tr_ch_o), 64'((first + i) % NUM_CH));
            step();
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        en_i       = 1'b1;
        clear_i    = 1'b0;
        ev_valid_i = '0;
        ev_data_i  = '0;
        tr_ready_i = 1'b1;
        model_reset();

        // Reset state (asynchronous, before any clock edge).
        #2 rst_i = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b1;
        compare_all();

        // Single event at ts=5, visible two cycles later.
        repeat (5) step();
        ev_valid_i = 4'b0001;
        ev_data_i[0 +: DATA_W] = 64'hDEAD_BEEF_0000_0001;
        step();
        ev_valid_i = '0;
        step();
        check("single_valid", 64'(tr_valid_o), 64'd1);
        check("single_ch", 64'(tr_ch_o), 64'd0);
        check("single_data", 64'(tr_data_o), 64'hDEAD_BEEF_0000_0001);
`ifdef TRACE_TS_EN
        check("single_ts", 64'(tr_ts_o), 64'd5);
`endif
        step();
        check("single_empty", 64'(count_o), 64'd0);

        // Round-robin ordering.
        do_clear();
        burst_order(0);
        burst_order(0);
        ev_valid_i = 4'b0010;
        step();
        ev_valid_i = '0;
        step();
        step();
        burst_order(2);

        // Full FIFO with backpressure: 16 stored, 1 held, 3 dropped.
        do_clear();
        tr_ready_i = 1'b0;
        for (int j = 0; j < 20; j++) begin
            ev_valid_i = 4'b0010;
            ev_data_i[1*DATA_W +: DATA_W] = 64'(j);
            step();
            ev_valid_i = '0;
            step();
        end
        check("full_count", 64'(count_o), 64'd16);
        check("full_drop", 64'(drop_cnt_o), 64'd3);
        check("full_ovf", 64'(overflow_o), 64'd1);
        tr_ready_i = 1'b1;
        for (int j = 0; j < 17; j++) begin
            check("drain_order", 64'(tr_data_o), 64'(j));
            step();
        end
        check("drain_empty", 64'(count_o), 64'd0);

        // Push and pop together at full occupancy.
        do_clear();
        tr_ready_i = 1'b0;
        for (int j = 0; j < 17; j++) begin
            ev_valid_i = (j < 16) ? 4'b0001 : 4'b0100;
            ev_data_i[0*DATA_W +: DATA_W] = 64'(j);
            ev_data_i[2*DATA_W +: DATA_W] = 64'hC2C2;
            step();
        end
        ev_valid_i = '0;
        step();
        check("pp_full", 64'(count_o), 64'd16);
        tr_ready_i = 1'b1;
        step();
        check("pp_hold16", 64'(count_o), 64'd16);
        for (int j = 0; j < 16; j++) begin
            if (j == 15) check("pp_tail_ch", 64'(tr_ch_o), 64'd2);
            step();
        end

        // Drop counter saturation, then clear.
        do_clear();
        tr_ready_i = 1'b0;
        ev_valid_i = '1;
        repeat (17600) begin
            for (int k = 0; k < NUM_CH; k++) ev_data_i[k*DATA_W +: DATA_W] = {$urandom, $urandom};
            step();
        end
        check("sat_drop", 64'(drop_cnt_o), 64'hFFFF);
        check("sat_ovf", 64'(overflow_o), 64'd1);
        do_clear();
        check("clr_count", 64'(count_o), 64'd0);
        check("clr_valid", 64'(tr_valid_o), 64'd0);
        check("clr_drop", 64'(drop_cnt_o), 64'd0);
        check("clr_ovf", 64'(overflow_o), 64'd0);
        tr_ready_i = 1'b1;
        ev_valid_i = 4'b1000;
        step();
        ev_valid_i = '0;
        step();
        check("clr_ts_restart", 64'(tr_ts_o), 64'd0);
        step();

        // Randomized traffic.
        repeat (3000) begin
            en_i       = ($urandom_range(0, 7) != 0);
            tr_ready_i = ($urandom_range(0, 2) != 0);
            clear_i    = ($urandom_range(0, 99) == 0);
            ev_valid_i = NUM_CH'($urandom);
            for (int k = 0; k < NUM_CH; k++) ev_data_i[k*DATA_W +: DATA_W] = {$urandom, $urandom};
            step();
        end
        clear_i = 1'b0;
        en_i    = 1'b1;
        do_clear();

        // Asynchronous reset mid-drain.
        tr_ready_i = 1'b0;
        ev_valid_i = 4'b0001;
        repeat (7) step();
        ev_valid_i = '0;
        step();
        check("mid_count", 64'(count_o), 64'd7);
        tr_ready_i = 1'b1;
        #2 rst_i = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        compare_all();
        repeat (3) step();
        ev_valid_i = 4'b0001;
        ev_data_i[0 +: DATA_W] = 64'h0123_4567_89AB_CDEF;
        step();
        ev_valid_i = '0;
        step();
        check("post_rst_ch", 64'(tr_ch_o), 64'd0);
        check("post_rst_valid", 64'(tr_valid_o), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
